dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory of the 3-stage pipeline between two requesters: port 0 is the core load/store path, port 1 is the debug/loader path.
- Port 1 preloads and inspects data memory without hierarchical pokes.
- Sits between the Datapath memory-stage signals and data_mem.
- Serialises accesses, arbitrates round-robin or fixed-priority, and tracks read latency so each response returns to its issuer.

Parameters:
- ADDR_W, 10, word address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 1, cycles from mem_en (read) to valid mem_rdata; legal range 1..7.
- FIXED_PRIO, 0, 1 = port 0 always wins ties; 0 = round-robin.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- m0_req, m1_req  in  1  request; held until granted.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  ADDR_W  word address.
- m0_wdata, m1_wdata  in  DATA_W  write data.
- m0_wmask, m1_wmask  in  DATA_W/8  byte write enables.
- m0_gnt, m1_gnt  out  1  request accepted this cycle (combinational).
- m0_rvalid, m1_rvalid  out  1  one-cycle read-data-valid pulse.
- m0_rdata, m1_rdata  out  DATA_W  read data; qualified by rvalid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wmask  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  read in flight (state WAIT).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. On reset:
  - state=IDLE, last_gnt=1, lat_cnt=0.
  - All gnt, rvalid, mem_en, mem_we and busy are 0.
  - rdata outputs are 0.
- FSM states: IDLE and WAIT.
- IDLE, arbitration:
  - If exactly one req is high, that port wins.
  - If both are high: with FIXED_PRIO=1, port 0 wins; otherwise the port != last_gnt wins.
- IDLE, on a grant (same cycle as req):
  - Winner's gnt=1; mem_en=1.
  - mem_we, mem_addr, mem_wdata and mem_wmask are driven from the winner's inputs.
  - last_gnt <= winner.
- Write grant: stays in IDLE, so back-to-back writes are allowed, one per cycle.
- Read grant: records the owner; lat_cnt <= MEM_LATENCY; next state is WAIT.
- WAIT:
  - No grants; mem_en=0; busy=1; lat_cnt decrements each cycle.
  - When lat_cnt==1: owner's rvalid=1 and owner's rdata=mem_rdata; next state is IDLE.
  - The other port's rdata holds its last value.
- Latency: read issued at cycle T gives rvalid at T+MEM_LATENCY. The next grant is possible at T+MEM_LATENCY+1.
- Idle memory outputs: when no grant, mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
- Request without a grant: the requester holds req and all operands stable. The arbiter never drops a held request; worst-case wait is one foreign transaction with round-robin.
- Req deasserted before grant: the request is ignored; no state change.
- Reset in WAIT: the pending rvalid is suppressed, and the FSM returns to IDLE next cycle.
- Width rules: addr and data pass through unchanged; no address translation.
- Assertions the verifier checks:
  - m0_gnt and m1_gnt never both 1.
  - mem_en implies exactly one gnt.
  - rvalid only to the port that issued the read.

Test Plan:
- Single write then read: m0 writes addr 2 = 32'h14, mask 4'hF. Next cycle, m0 reads addr 2 with MEM_LATENCY=1. Expect gnt on both cycles and m0_rvalid one cycle after the read grant with m0_rdata=32'h14.
- Contention, round-robin: after reset, m0 and m1 both read addr 0 (mem holds 5) and hold req. Expect m0 granted first (last_gnt=1 at reset), m1 granted two cycles later, and both rvalid pulses return 32'h5 in order m0 then m1.
- FIXED_PRIO=1: both ports issue continuous writes. Expect m0_gnt every cycle and m1_gnt never while m0_req is high; m1 is granted the cycle after m0_req drops.
- Latency sweep: MEM_LATENCY=3, m1 reads addr 4 (mem holds 40). Expect busy=1 for 3 cycles, m1_rvalid in the 3rd, m1_rdata=32'h28, and no grant to a waiting m0 until the following cycle.
- Byte mask: m0 writes 32'hAABBCCDD with mask 4'b0011 to addr 1 (previously 10). A read returns 32'h0000CCDD.
- Reset mid-read: MEM_LATENCY=3, reset asserted one cycle after the read grant. Expect no rvalid, busy=0 after reset, and the next request granted normally with port 0 preferred on a tie.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: port 0 is the core
// load/store path, port 1 the debug/loader path. Reads block further grants until data returns.
module dmem_arbiter #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1,
  parameter bit          FIXED_PRIO  = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int unsigned CntW = 3;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              owner_q, owner_d;
  logic [CntW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic win_valid;
  logic winner;
  logic resp;

  // Reset masks every strobe in the same cycle so a pending read never completes under reset.
  always_comb begin
    win_valid = 1'b0;
    winner    = 1'b0;
    if (!reset && (state_q == StIdle)) begin
      if (m0_req && m1_req) begin
        win_valid = 1'b1;
        winner    = FIXED_PRIO ? 1'b0 : ~last_gnt_q;
      end else if (m0_req) begin
        win_valid = 1'b1;
      end else if (m1_req) begin
        win_valid = 1'b1;
        winner    = 1'b1;
      end
    end
  end

  assign resp   = !reset && (state_q == StWait) && (lat_cnt_q == CntW'(1));
  assign busy   = !reset && (state_q == StWait);
  assign m0_gnt = win_valid & ~winner;
  assign m1_gnt = win_valid & winner;

  always_comb begin
    mem_en    = win_valid;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (win_valid) begin
      if (winner) begin
        mem_we    = m1_we;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_wmask = m1_wmask;
      end else begin
        mem_we    = m0_we;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_wmask = m0_wmask;
      end
    end
  end

  assign m0_rvalid = resp & ~owner_q;
  assign m1_rvalid = resp & owner_q;
  assign m0_rdata  = m0_rvalid ? mem_rdata : rdata0_q;
  assign m1_rdata  = m1_rvalid ? mem_rdata : rdata1_q;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    lat_cnt_d  = lat_cnt_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    case (state_q)
      StIdle: begin
        if (win_valid) begin
          last_gnt_d = winner;
          // Writes retire in the grant cycle, so only reads occupy the memory.
          if (!mem_we) begin
            owner_d   = winner;
            lat_cnt_d = CntW'(MEM_LATENCY);
            state_d   = StWait;
          end
        end
      end
      StWait: begin
        lat_cnt_d = lat_cnt_q - CntW'(1);
        if (lat_cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (owner_q) begin
            rdata1_d = mem_rdata;
          end else begin
            rdata0_d = mem_rdata;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      lat_cnt_q  <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      owner_q    <= owner_d;
      lat_cnt_q  <= lat_cnt_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance 0 is round-robin with latency 1, instance 1 is fixed
// priority with latency 3. A cycle-indexed model checks every output each cycle.
module tb_dmem_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req    [2][2];
  logic        we     [2][2];
  logic [9:0]  addr   [2][2];
  logic [31:0] wdata  [2][2];
  logic [3:0]  wmask  [2][2];
  logic        gnt    [2][2];
  logic        rvalid [2][2];
  logic [31:0] rdata  [2][2];

  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [9:0]  mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_wmask [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];

  int   total  = 0;
  int   bad    = 0;
  logic chk_on = 1'b0;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LATENCY(1), .FIXED_PRIO(1'b0)) dut_a (
    .clk(clk), .reset(reset),
    .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_addr(addr[0][0]), .m0_wdata(wdata[0][0]),
    .m0_wmask(wmask[0][0]), .m0_gnt(gnt[0][0]), .m0_rvalid(rvalid[0][0]), .m0_rdata(rdata[0][0]),
    .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_addr(addr[0][1]), .m1_wdata(wdata[0][1]),
    .m1_wmask(wmask[0][1]), .m1_gnt(gnt[0][1]), .m1_rvalid(rvalid[0][1]), .m1_rdata(rdata[0][1]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_wmask(mem_wmask[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LATENCY(3), .FIXED_PRIO(1'b1)) dut_b (
    .clk(clk), .reset(reset),
    .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_addr(addr[1][0]), .m0_wdata(wdata[1][0]),
    .m0_wmask(wmask[1][0]), .m0_gnt(gnt[1][0]), .m0_rvalid(rvalid[1][0]), .m0_rdata(rdata[1][0]),
    .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_addr(addr[1][1]), .m1_wdata(wdata[1][1]),
    .m1_wmask(wmask[1][1]), .m1_gnt(gnt[1][1]), .m1_rvalid(rvalid[1][1]), .m1_rdata(rdata[1][1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_wmask(mem_wmask[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  // Memory behind each arbiter; the read pipe carries a poison word when no read was issued.
  for (genvar g = 0; g < 2; g++) begin : g_env
    localparam int Lat = (g == 0) ? 1 : 3;
    logic [31:0] mem  [1024];
    logic [31:0] pipe [3];
    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wmask[g][b]) mem[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
        end
      end
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g]] : 32'hDEAD_BEEF;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign mem_rdata[g] = pipe[Lat-1];
  end

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h", name, d, act, exp);
    end
  endtask

  // Model state: absolute cycle numbers for when the memory frees and when data is due.
  int          cyc = 0;
  int          m_busy_until [2];
  int          m_due        [2];
  int          m_last       [2];
  int          m_owner      [2];
  logic [31:0] m_pend       [2];
  logic [31:0] m_hold       [2][2];
  logic [31:0] m_mem        [2][1024];

  initial begin : model
    int          lat;
    int          win;
    logic        fp;
    logic        e_gnt [2];
    logic        e_rv  [2];
    logic [31:0] e_rd  [2];
    logic        e_en, e_we, e_busy;
    logic [9:0]  e_addr;
    logic [31:0] e_wd;
    logic [3:0]  e_wm;
    for (int d = 0; d < 2; d++) begin
      m_busy_until[d] = -1;
      m_due[d]        = -1;
      m_last[d]       = 1;
      m_owner[d]      = 0;
      m_pend[d]       = '0;
      m_hold[d][0]    = '0;
      m_hold[d][1]    = '0;
      for (int a = 0; a < 1024; a++) m_mem[d][a] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        lat    = (d == 0) ? 1 : 3;
        fp     = (d == 1);
        win    = -1;
        e_en   = 1'b0;
        e_we   = 1'b0;
        e_busy = 1'b0;
        e_addr = '0;
        e_wd   = '0;
        e_wm   = '0;
        for (int p = 0; p < 2; p++) begin
          e_gnt[p] = 1'b0;
          e_rv[p]  = 1'b0;
          e_rd[p]  = m_hold[d][p];
        end
        if (!reset) begin
          if (cyc <= m_busy_until[d]) begin
            e_busy = 1'b1;
            if (cyc == m_due[d]) begin
              e_rv[m_owner[d]] = 1'b1;
              e_rd[m_owner[d]] = m_pend[d];
            end
          end else begin
            if (req[d][0] && req[d][1]) win = fp ? 0 : 1 - m_last[d];
            else if (req[d][0]) win = 0;
            else if (req[d][1]) win = 1;
            if (win >= 0) begin
              e_gnt[win] = 1'b1;
              e_en       = 1'b1;
              e_we       = we[d][win];
              e_addr     = addr[d][win];
              e_wd       = wdata[d][win];
              e_wm       = wmask[d][win];
            end
          end
        end
        if (chk_on) begin
          check("gnt0", d, 32'(gnt[d][0]), 32'(e_gnt[0]));
          check("gnt1", d, 32'(gnt[d][1]), 32'(e_gnt[1]));
          check("gnt_excl", d, 32'(gnt[d][0] & gnt[d][1]), 32'd0);
          check("rvalid0", d, 32'(rvalid[d][0]), 32'(e_rv[0]));
          check("rvalid1", d, 32'(rvalid[d][1]), 32'(e_rv[1]));
          check("rdata0", d, rdata[d][0], e_rd[0]);
          check("rdata1", d, rdata[d][1], e_rd[1]);
          check("mem_en", d, 32'(mem_en[d]), 32'(e_en));
          check("mem_we", d, 32'(mem_we[d]), 32'(e_we));
          check("mem_addr", d, 32'(mem_addr[d]), 32'(e_addr));
          check("mem_wdata", d, mem_wdata[d], e_wd);
          check("mem_wmask", d, 32'(mem_wmask[d]), 32'(e_wm));
          check("busy", d, 32'(busy[d]), 32'(e_busy));
        end
        if (reset) begin
          m_busy_until[d] = -1;
          m_due[d]        = -1;
          m_last[d]       = 1;
          m_hold[d][0]    = '0;
          m_hold[d][1]    = '0;
        end else begin
          for (int p = 0; p < 2; p++) if (e_rv[p]) m_hold[d][p] = m_pend[d];
          if (win >= 0) begin
            m_last[d] = win;
            if (e_we) begin
              for (int b = 0; b < 4; b++) begin
                if (e_wm[b]) m_mem[d][e_addr][8*b +: 8] = e_wd[8*b +: 8];
              end
            end else begin
              m_pend[d]       = m_mem[d][e_addr];
              m_owner[d]      = win;
              m_due[d]        = cyc + lat;
              m_busy_until[d] = cyc + lat;
            end
          end
        end
      end
      cyc++;
    end
  end

  // Call at posedge+1; returns at posedge+1 of the cycle after the grant.
  task automatic issue(input int d, input int p, input logic w, input logic [9:0] a,
                       input logic [31:0] wd, input logic [3:0] wm, output int waited);
    logic got;
    got    = 1'b0;
    waited = -1;
    req[d][p]   = 1'b1;
    we[d][p]    = w;
    addr[d][p]  = a;
    wdata[d][p] = wd;
    wmask[d][p] = wm;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (gnt[d][p]) begin
        got    = 1'b1;
        waited = i;
      end
      @(posedge clk);
      #1;
    end
    req[d][p] = 1'b0;
    we[d][p]  = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin : stim
    int w, w0, w1;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        req[d][p]   = 1'b0;
        we[d][p]    = 1'b0;
        addr[d][p]  = '0;
        wdata[d][p] = '0;
        wmask[d][p] = '0;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_on = 1'b1;

    // Preload through the loader port.
    issue(0, 1, 1'b1, 10'd0, 32'd5,  4'hF, w); check("pre_a0", 0, 32'(w), 32'd0);
    issue(0, 1, 1'b1, 10'd1, 32'd10, 4'hF, w); check("pre_a1", 0, 32'(w), 32'd0);
    issue(1, 1, 1'b1, 10'd0, 32'd5,  4'hF, w); check("pre_b0", 1, 32'(w), 32'd0);
    issue(1, 1, 1'b1, 10'd4, 32'd40, 4'hF, w); check("pre_b4", 1, 32'(w), 32'd0);
    pulse_reset();

    // Write then read back, latency 1.
    issue(0, 0, 1'b1, 10'd2, 32'h14, 4'hF, w); check("wr_gnt", 0, 32'(w), 32'd0);
    issue(0, 0, 1'b0, 10'd2, 32'h0, 4'h0, w);  check("rd_gnt", 0, 32'(w), 32'd0);
    @(negedge clk);
    check("wr_rd_rvalid", 0, 32'(rvalid[0][0]), 32'd1);
    check("wr_rd_rdata", 0, rdata[0][0], 32'h14);
    @(posedge clk);
    #1;

    // Round-robin contention just after reset: port 0 first.
    pulse_reset();
    fork
      begin
        issue(0, 0, 1'b0, 10'd0, 32'h0, 4'h0, w0);
        check("rr_m0_wait", 0, 32'(w0), 32'd0);
        @(negedge clk);
        check("rr_m0_rvalid", 0, 32'(rvalid[0][0]), 32'd1);
        check("rr_m0_rdata", 0, rdata[0][0], 32'h5);
      end
      begin
        issue(0, 1, 1'b0, 10'd0, 32'h0, 4'h0, w1);
        check("rr_m1_wait", 0, 32'(w1), 32'd2);
        @(negedge clk);
        check("rr_m1_rvalid", 0, 32'(rvalid[0][1]), 32'd1);
        check("rr_m1_rdata", 0, rdata[0][1], 32'h5);
      end
    join
    @(posedge clk);
    #1;

    // Partial byte write over 10.
    issue(0, 0, 1'b1, 10'd1, 32'hAABB_CCDD, 4'b0011, w); check("mask_wr", 0, 32'(w), 32'd0);
    issue(0, 0, 1'b0, 10'd1, 32'h0, 4'h0, w);             check("mask_rd", 0, 32'(w), 32'd0);
    @(negedge clk);
    check("mask_rvalid", 0, 32'(rvalid[0][0]), 32'd1);
    check("mask_rdata", 0, rdata[0][0], 32'h0000_CCDD);
    @(posedge clk);
    #1;

    // Fixed priority with continuous writes from both ports.
    req[1][0] = 1'b1; we[1][0] = 1'b1; wmask[1][0] = 4'hF;
    req[1][1] = 1'b1; we[1][1] = 1'b1; wmask[1][1] = 4'hF;
    addr[1][1] = 10'd20; wdata[1][1] = 32'h77;
    for (int i = 0; i < 4; i++) begin
      addr[1][0]  = 10'(16 + i);
      wdata[1][0] = 32'(100 + i);
      @(negedge clk);
      check("fp_m0_gnt", 1, 32'(gnt[1][0]), 32'd1);
      check("fp_m1_held", 1, 32'(gnt[1][1]), 32'd0);
      @(posedge clk);
      #1;
    end
    req[1][0] = 1'b0; we[1][0] = 1'b0;
    @(negedge clk);
    check("fp_m1_gnt", 1, 32'(gnt[1][1]), 32'd1);
    @(posedge clk);
    #1;
    req[1][1] = 1'b0; we[1][1] = 1'b0;

    // Latency 3: m1 reads 40 while m0 waits behind it.
    req[1][1] = 1'b1; addr[1][1] = 10'd4;
    @(negedge clk);
    check("lat_m1_gnt", 1, 32'(gnt[1][1]), 32'd1);
    @(posedge clk);
    #1;
    req[1][1] = 1'b0;
    req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 10'd0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("lat_busy", 1, 32'(busy[1]), 32'd1);
      check("lat_m0_blocked", 1, 32'(gnt[1][0]), 32'd0);
      check("lat_m1_rvalid", 1, 32'(rvalid[1][1]), 32'(k == 3));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("lat_m0_gnt", 1, 32'(gnt[1][0]), 32'd1);
    check("lat_idle", 1, 32'(busy[1]), 32'd0);
    check("lat_m1_hold", 1, rdata[1][1], 32'h28);
    @(posedge clk);
    #1;
    req[1][0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset one cycle after a read grant.
    req[1][0] = 1'b1; addr[1][0] = 10'd4;
    @(negedge clk);
    check("rst_rd_gnt", 1, 32'(gnt[1][0]), 32'd1);
    @(posedge clk);
    #1;
    req[1][0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_no_rvalid", 1, 32'(rvalid[1][0]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req[1][0] = 1'b1; addr[1][0] = 10'd0;
    req[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 10'd0;
    @(negedge clk);
    check("rst_busy_clear", 1, 32'(busy[1]), 32'd0);
    check("rst_m0_wins", 1, 32'(gnt[1][0]), 32'd1);
    check("rst_m1_waits", 1, 32'(gnt[1][1]), 32'd0);
    @(posedge clk);
    #1;
    req[1][0] = 1'b0;
    issue(1, 1, 1'b0, 10'd0, 32'h0, 4'h0, w);
    check("rst_m1_wait", 1, 32'(w), 32'd3);
    repeat (5) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
